// File: rtl/d_sram_bridge.sv
// rtl/d_sram_bridge.sv - mem-stage load/store to SRAM-like data bus bridge
//
// Converts a single mem-stage load/store into one SRAM-like bus transaction
// (request/addr_ok phase, then data_ok phase). It stalls the pipeline while
// the transaction is in flight, then parks in DONE until the pipeline
// advances, so that a stalled instruction is never reissued.
//
// Optional feature: define KSEG_MAP_EN to map kseg0/kseg1 virtual
// addresses (0x8000_0000-0xBFFF_FFFF) to physical by clearing bits [31:29].
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_mem_en             mem-stage load/store valid
//   i_mem_wen[3:0]       byte write strobes, 0 = read
//   i_mem_size[1:0]      0=byte, 1=half, 2=word
//   i_mem_addr[31:0]     virtual data address
//   i_mem_wdata[31:0]    lane-aligned store data
//   i_mem_flush          exception flush in mem stage
//   i_longest_stall      pipeline-wide stall, low = mem stage advances
//   o_mem_rdata[31:0]    load data held for the datapath
//   o_d_stall            data-side stall to the hazard unit
//   o_data_req/_wr/_size/_addr/_wdata   SRAM-like request channel
//   i_data_addr_ok       request accepted
//   i_data_data_ok       response valid / write done
//   i_data_rdata[31:0]   bus read data

module d_sram_bridge (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_en,
  input  logic [3:0]  i_mem_wen,
  input  logic [1:0]  i_mem_size,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_mem_flush,
  input  logic        i_longest_stall,
  output logic [31:0] o_mem_rdata,
  output logic        o_d_stall,
  output logic        o_data_req,
  output logic        o_data_wr,
  output logic [1:0]  o_data_size,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_wdata,
  input  logic        i_data_addr_ok,
  input  logic        i_data_data_ok,
  input  logic [31:0] i_data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_start;
  logic        w_resp;
  logic [31:0] w_phys_addr;

  // A flushed instruction never starts a transaction.
  assign w_start = i_mem_en & ~i_mem_flush;

  // The response completes the transaction either together with the
  // address handshake in REQ, or later in WAIT.
  assign w_resp = ((r_state == REQ) & i_data_addr_ok & i_data_data_ok) |
                  ((r_state == WAIT) & i_data_data_ok);

`ifdef KSEG_MAP_EN
  // kseg0/kseg1 share the 0b10 prefix; both are unmapped windows onto
  // the low 512 MiB of physical memory.
  assign w_phys_addr = (i_mem_addr[31:30] == 2'b10) ?
                       {3'b000, i_mem_addr[28:0]} : i_mem_addr;
`else
  assign w_phys_addr = i_mem_addr;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next_state = REQ;
      end
      REQ: begin
        if (i_data_addr_ok) begin
          w_next_state = i_data_data_ok ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (i_data_data_ok) w_next_state = DONE;
      end
      DONE: begin
        // Park until the pipeline advances past this instruction.
        if (!i_longest_stall) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request attributes are captured once so the bus sees stable values
  // even if the pipeline inputs change while the access is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if ((r_state == IDLE) && w_start) begin
      r_wr    <= |i_mem_wen;
      r_size  <= i_mem_size;
      r_addr  <= w_phys_addr;
      r_wdata <= i_mem_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 32'd0;
    end else if (w_resp && !r_wr) begin
      r_rdata <= i_data_rdata;
    end
  end

  always_comb begin
    o_d_stall = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        IDLE:    o_d_stall = w_start;
        REQ:     o_d_stall = 1'b1;
        WAIT:    o_d_stall = 1'b1;
        DONE:    o_d_stall = 1'b0;
        default: o_d_stall = 1'b0;
      endcase
    end
  end

  // Request is suppressed during the reset cycle so nothing new is issued
  // while an interrupted transaction is being abandoned.
  assign o_data_req   = (r_state == REQ) & ~i_rst;
  assign o_data_wr    = r_wr;
  assign o_data_size  = r_size;
  assign o_data_addr  = r_addr;
  assign o_data_wdata = r_wdata;
  assign o_mem_rdata  = r_rdata;

endmodule
